// File: rtl/axi_mem_initiator_if.sv
// AXI4 bus bundle between the memory initiator (master) and a memory slave.
// Signal names keep the initiator-side _o/_i direction suffixes.
interface axi_mem_initiator_if #(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned UserWidth = 1
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic [IdWidth-1:0]   aw_id_o;
  logic [AddrWidth-1:0] aw_addr_o;
  logic [7:0]           aw_len_o;
  logic [2:0]           aw_size_o;
  logic [1:0]           aw_burst_o;
  logic                 aw_lock_o;
  logic [3:0]           aw_cache_o;
  logic [2:0]           aw_prot_o;
  logic [3:0]           aw_qos_o;
  logic [3:0]           aw_region_o;
  logic [5:0]           aw_atop_o;
  logic [UserWidth-1:0] aw_user_o;
  logic                 aw_valid_o;
  logic                 aw_ready_i;

  logic [DataWidth-1:0] w_data_o;
  logic [StrbWidth-1:0] w_strb_o;
  logic                 w_last_o;
  logic [UserWidth-1:0] w_user_o;
  logic                 w_valid_o;
  logic                 w_ready_i;

  logic [IdWidth-1:0]   b_id_i;
  logic [1:0]           b_resp_i;
  logic [UserWidth-1:0] b_user_i;
  logic                 b_valid_i;
  logic                 b_ready_o;

  logic [IdWidth-1:0]   ar_id_o;
  logic [AddrWidth-1:0] ar_addr_o;
  logic [7:0]           ar_len_o;
  logic [2:0]           ar_size_o;
  logic [1:0]           ar_burst_o;
  logic                 ar_lock_o;
  logic [3:0]           ar_cache_o;
  logic [2:0]           ar_prot_o;
  logic [3:0]           ar_qos_o;
  logic [3:0]           ar_region_o;
  logic [UserWidth-1:0] ar_user_o;
  logic                 ar_valid_o;
  logic                 ar_ready_i;

  logic [IdWidth-1:0]   r_id_i;
  logic [DataWidth-1:0] r_data_i;
  logic [1:0]           r_resp_i;
  logic                 r_last_i;
  logic [UserWidth-1:0] r_user_i;
  logic                 r_valid_i;
  logic                 r_ready_o;

  modport master (
    output aw_id_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, aw_lock_o, aw_cache_o,
           aw_prot_o, aw_qos_o, aw_region_o, aw_atop_o, aw_user_o, aw_valid_o,
    input  aw_ready_i,
    output w_data_o, w_strb_o, w_last_o, w_user_o, w_valid_o,
    input  w_ready_i,
    input  b_id_i, b_resp_i, b_user_i, b_valid_i,
    output b_ready_o,
    output ar_id_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_lock_o, ar_cache_o,
           ar_prot_o, ar_qos_o, ar_region_o, ar_user_o, ar_valid_o,
    input  ar_ready_i,
    input  r_id_i, r_data_i, r_resp_i, r_last_i, r_user_i, r_valid_i,
    output r_ready_o
  );

  modport slave (
    input  aw_id_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, aw_lock_o, aw_cache_o,
           aw_prot_o, aw_qos_o, aw_region_o, aw_atop_o, aw_user_o, aw_valid_o,
    output aw_ready_i,
    input  w_data_o, w_strb_o, w_last_o, w_user_o, w_valid_o,
    output w_ready_i,
    output b_id_i, b_resp_i, b_user_i, b_valid_i,
    input  b_ready_o,
    input  ar_id_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_lock_o, ar_cache_o,
           ar_prot_o, ar_qos_o, ar_region_o, ar_user_o, ar_valid_o,
    output ar_ready_i,
    output r_id_i, r_data_i, r_resp_i, r_last_i, r_user_i, r_valid_i,
    input  r_ready_o
  );
endinterface

// File: rtl/axi_mem_initiator.sv
// Single-outstanding AXI4 burst initiator: turns one command into an AR/R or AW/W/B
// sequence, streaming data straight through with no buffering.
module axi_mem_initiator #(
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiUserWidth = 1,
  parameter int unsigned TxnId        = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [AxiAddrWidth-1:0]   cmd_addr_i,
  input  logic [7:0]                cmd_len_i,
  input  logic [AxiDataWidth-1:0]   wdata_i,
  input  logic [AxiDataWidth/8-1:0] wstrb_i,
  input  logic                      wdata_valid_i,
  output logic                      wdata_ready_o,
  output logic [AxiDataWidth-1:0]   rdata_o,
  output logic                      rdata_last_o,
  output logic                      rdata_valid_o,
  input  logic                      rdata_ready_i,
  output logic                      done_o,
  output logic                      err_o,
  output logic [2:0]                state_o,
  axi_mem_initiator_if.master       axi
);
  // Handshake rule on every channel: a beat transfers on the rising edge where
  // valid && ready; a raised valid stays up with stable payload until that edge.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_AR = 3'd1, ST_R = 3'd2, ST_AW = 3'd3, ST_W = 3'd4, ST_B = 3'd5
  } state_e;

  localparam int unsigned           StrbWidth = AxiDataWidth / 8;
  localparam logic [2:0]            BeatSize  = 3'($clog2(StrbWidth));
  localparam logic [1:0]            BurstIncr = 2'b01;
  localparam logic [1:0]            RespOkay  = 2'b00;
  localparam logic [AxiIdWidth-1:0] IdExp     = AxiIdWidth'(TxnId);

  state_e                  state_q;
  logic [AxiAddrWidth-1:0] addr_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic                    err_acc_q;
  logic                    err_q;
  logic                    done_q;

  logic [31:0] burst_end;
  logic        crosses_4k;
  logic        cmd_fire, r_fire, w_fire;
  logic        r_err_d, b_err_d;

  // Byte offset within the 4 KB page just past the final beat.
  assign burst_end  = {20'd0, cmd_addr_i[11:0]}
                    + ((32'(cmd_len_i) + 32'd1) << $clog2(StrbWidth));
  assign crosses_4k = burst_end > 32'd4096;

  assign cmd_ready_o = rst_ni && (state_q == ST_IDLE);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign r_fire      = (state_q == ST_R) && axi.r_valid_i && rdata_ready_i;
  assign w_fire      = (state_q == ST_W) && wdata_valid_i && axi.w_ready_i;

  assign r_err_d = (axi.r_resp_i != RespOkay) || (axi.r_id_i != IdExp)
                || (axi.r_last_i && (cnt_q != len_q))
                || (!axi.r_last_i && (cnt_q == len_q));
  assign b_err_d = (axi.b_resp_i != RespOkay) || (axi.b_id_i != IdExp);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_acc_q <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            addr_q    <= cmd_addr_i;
            len_q     <= cmd_len_i;
            cnt_q     <= '0;
            err_acc_q <= 1'b0;
            if (crosses_4k) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              err_q   <= 1'b0;
              state_q <= cmd_write_i ? ST_AW : ST_AR;
            end
          end
        end
        ST_AR: begin
          if (axi.ar_ready_i) begin
            state_q <= ST_R;
            cnt_q   <= '0;
          end
        end
        ST_R: begin
          // The burst ends on the slave's last beat; the counter saturates so an
          // overlong burst cannot alias back onto len.
          if (r_fire) begin
            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            if (r_err_d) err_acc_q <= 1'b1;
            if (axi.r_last_i) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              done_q  <= 1'b1;
              err_q   <= err_acc_q || r_err_d;
            end
          end
        end
        ST_AW: begin
          if (axi.aw_ready_i) begin
            state_q <= ST_W;
            cnt_q   <= '0;
          end
        end
        ST_W: begin
          if (w_fire) begin
            if (cnt_q == len_q) begin
              state_q <= ST_B;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        ST_B: begin
          if (axi.b_valid_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            err_q   <= err_acc_q || b_err_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

  assign axi.ar_id_o     = IdExp;
  assign axi.ar_addr_o   = addr_q;
  assign axi.ar_len_o    = len_q;
  assign axi.ar_size_o   = BeatSize;
  assign axi.ar_burst_o  = BurstIncr;
  assign axi.ar_lock_o   = 1'b0;
  assign axi.ar_cache_o  = 4'b0010;
  assign axi.ar_prot_o   = 3'b000;
  assign axi.ar_qos_o    = 4'd0;
  assign axi.ar_region_o = 4'd0;
  assign axi.ar_user_o   = '0;
  assign axi.ar_valid_o  = (state_q == ST_AR);

  assign axi.r_ready_o = (state_q == ST_R) && rdata_ready_i;
  assign rdata_valid_o = (state_q == ST_R) && axi.r_valid_i;
  assign rdata_o       = axi.r_data_i;
  assign rdata_last_o  = (state_q == ST_R) && (cnt_q == len_q);

  assign axi.aw_id_o     = IdExp;
  assign axi.aw_addr_o   = addr_q;
  assign axi.aw_len_o    = len_q;
  assign axi.aw_size_o   = BeatSize;
  assign axi.aw_burst_o  = BurstIncr;
  assign axi.aw_lock_o   = 1'b0;
  assign axi.aw_cache_o  = 4'b0010;
  assign axi.aw_prot_o   = 3'b000;
  assign axi.aw_qos_o    = 4'd0;
  assign axi.aw_region_o = 4'd0;
  assign axi.aw_atop_o   = 6'd0;
  assign axi.aw_user_o   = '0;
  assign axi.aw_valid_o  = (state_q == ST_AW);

  assign axi.w_valid_o = (state_q == ST_W) && wdata_valid_i;
  assign wdata_ready_o = (state_q == ST_W) && axi.w_ready_i;
  assign axi.w_data_o  = wdata_i;
  assign axi.w_strb_o  = wstrb_i;
  assign axi.w_last_o  = (state_q == ST_W) && (cnt_q == len_q);
  assign axi.w_user_o  = '0;

  assign axi.b_ready_o = (state_q == ST_B);

  logic unused_user;
  assign unused_user = ^{axi.b_user_i, axi.r_user_i};
endmodule

// File: tb/tb_axi_mem_initiator.sv
// Directed bench for axi_mem_initiator: a table of commands with hand-computed
// outcomes, a lock-step slave model, plus a mid-burst reset sequence.
module tb_axi_mem_initiator;
  localparam int unsigned IdW = 4;
  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 64;
  localparam int unsigned UW  = 1;
  localparam int unsigned TID = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic [DW-1:0] wdata = '0;
  logic [7:0]    wstrb = '0;
  logic          wdata_valid = 1'b0, wdata_ready;
  logic [DW-1:0] rdata;
  logic          rdata_last, rdata_valid, rdata_ready = 1'b0;
  logic          done, err;
  logic [2:0]    state;

  axi_mem_initiator_if #(.IdWidth(IdW), .AddrWidth(AW), .DataWidth(DW), .UserWidth(UW)) axi ();

  axi_mem_initiator #(
    .AxiIdWidth(IdW), .AxiAddrWidth(AW), .AxiDataWidth(DW), .AxiUserWidth(UW), .TxnId(TID)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wdata_i(wdata), .wstrb_i(wstrb), .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready),
    .rdata_o(rdata), .rdata_last_o(rdata_last), .rdata_valid_o(rdata_valid),
    .rdata_ready_i(rdata_ready),
    .done_o(done), .err_o(err), .state_o(state),
    .axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [7:0]  len;
    int          err_beat;   // read beat answered with SLVERR, -1 none
    int          last_at;    // read beat carrying r_last, -1 means beat len
    int          stall_at;   // beat preceded by a consumer/slave stall, -1 none
    int          stall_n;
    logic        bad_b_resp;
    logic        bad_b_id;
    logic        reject;
    logic        exp_err;
    logic [63:0] base;
  } vec_t;

  vec_t          vecs[12];
  vec_t          fresh;
  logic [DW-1:0] exp_q[$];
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_slave();
    axi.aw_ready_i = 1'b0; axi.w_ready_i = 1'b0; axi.ar_ready_i = 1'b0;
    axi.b_valid_i = 1'b0; axi.b_resp_i = 2'b00; axi.b_id_i = IdW'(TID); axi.b_user_i = '0;
    axi.r_valid_i = 1'b0; axi.r_last_i = 1'b0; axi.r_resp_i = 2'b00; axi.r_id_i = IdW'(TID);
    axi.r_data_i = '0; axi.r_user_i = '0;
    wdata_valid = 1'b0; rdata_ready = 1'b0; cmd_valid = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic exp_err);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_idle"}, state, 3'd0);
    @(posedge clk); #2;
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_err_hold"}, err, exp_err);
  endtask

  task automatic do_txn(input vec_t v);
    int nbeats;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
    #1 chk("cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    #1;
    if (v.reject) begin
      chk("rej_done", done, 1'b1);
      chk("rej_err", err, 1'b1);
      chk("rej_no_ar", axi.ar_valid_o, 1'b0);
      chk("rej_no_aw", axi.aw_valid_o, 1'b0);
      @(posedge clk); #2;
      chk("rej_done_pulse", done, 1'b0);
      chk("rej_still_no_ar", axi.ar_valid_o | axi.aw_valid_o, 1'b0);
      return;
    end
    chk("err_cleared", err, 1'b0);
    chk("busy_not_ready", cmd_ready, 1'b0);
    if (!v.wr) begin
      chk("ar_valid", axi.ar_valid_o, 1'b1);
      chk("ar_addr", axi.ar_addr_o, v.addr);
      chk("ar_len", axi.ar_len_o, v.len);
      chk("ar_size", axi.ar_size_o, 3'd3);
      chk("ar_burst", axi.ar_burst_o, 2'b01);
      chk("ar_id", axi.ar_id_o, IdW'(TID));
      @(posedge clk); #1;
      axi.ar_ready_i = 1'b1;
      #1 chk("ar_valid_held", axi.ar_valid_o, 1'b1);
      chk("ar_addr_stable", axi.ar_addr_o, v.addr);
      @(posedge clk); #1;
      axi.ar_ready_i = 1'b0;
      nbeats = (v.last_at < 0) ? int'(v.len) + 1 : v.last_at + 1;
      for (int b = 0; b < nbeats; b++) exp_q.push_back(v.base + 64'(b));
      for (int b = 0; b < nbeats; b++) begin
        axi.r_valid_i = 1'b1; axi.r_data_i = v.base + 64'(b);
        axi.r_resp_i = (b == v.err_beat) ? 2'b10 : 2'b00;
        axi.r_last_i = (b == nbeats - 1); axi.r_id_i = IdW'(TID);
        if (b == v.stall_at) begin
          for (int s = 0; s < v.stall_n; s++) begin
            rdata_ready = 1'b0;
            #1 chk("r_ready_stall", axi.r_ready_o, 1'b0);
            chk("rdata_valid_stall", rdata_valid, 1'b1);
            @(posedge clk); #1;
          end
        end
        rdata_ready = 1'b1;
        #1 chk("r_ready", axi.r_ready_o, 1'b1);
        chk("rdata_valid", rdata_valid, 1'b1);
        chk("rdata", rdata, exp_q.pop_front());
        chk("rdata_last", rdata_last, (b == int'(v.len)));
        @(posedge clk); #1;
      end
      axi.r_valid_i = 1'b0; axi.r_last_i = 1'b0; axi.r_resp_i = 2'b00; rdata_ready = 1'b0;
      #1 check_done("rd", v.exp_err);
    end else begin
      wdata_valid = 1'b1; wdata = v.base; axi.w_ready_i = 1'b1;
      #1 chk("aw_valid", axi.aw_valid_o, 1'b1);
      chk("aw_addr", axi.aw_addr_o, v.addr);
      chk("aw_len", axi.aw_len_o, v.len);
      chk("aw_size", axi.aw_size_o, 3'd3);
      chk("aw_burst", axi.aw_burst_o, 2'b01);
      chk("aw_id", axi.aw_id_o, IdW'(TID));
      chk("no_w_before_aw", axi.w_valid_o, 1'b0);
      chk("no_wready_before_aw", wdata_ready, 1'b0);
      @(posedge clk); #1;
      axi.aw_ready_i = 1'b1;
      #1 chk("aw_valid_held", axi.aw_valid_o, 1'b1);
      @(posedge clk); #1;
      axi.aw_ready_i = 1'b0;
      for (int b = 0; b <= int'(v.len); b++) exp_q.push_back(v.base + 64'(b));
      for (int b = 0; b <= int'(v.len); b++) begin
        wdata = v.base + 64'(b); wstrb = 8'hFF - 8'(b);
        if (b == v.stall_at) begin
          for (int s = 0; s < v.stall_n; s++) begin
            axi.w_ready_i = 1'b0;
            #1 chk("wdata_ready_stall", wdata_ready, 1'b0);
            chk("w_valid_stall", axi.w_valid_o, 1'b1);
            chk("w_last_stall", axi.w_last_o, (b == int'(v.len)));
            @(posedge clk); #1;
          end
        end
        axi.w_ready_i = 1'b1;
        #1 chk("w_valid", axi.w_valid_o, 1'b1);
        chk("wdata_ready", wdata_ready, 1'b1);
        chk("w_data", axi.w_data_o, exp_q.pop_front());
        chk("w_strb", axi.w_strb_o, 8'hFF - 8'(b));
        chk("w_last", axi.w_last_o, (b == int'(v.len)));
        chk("b_ready_early", axi.b_ready_o, 1'b0);
        @(posedge clk); #1;
      end
      wdata_valid = 1'b0; axi.w_ready_i = 1'b0;
      #1 chk("b_ready", axi.b_ready_o, 1'b1);
      chk("w_valid_in_b", axi.w_valid_o, 1'b0);
      @(posedge clk); #1;
      axi.b_valid_i = 1'b1;
      axi.b_resp_i = v.bad_b_resp ? 2'b10 : 2'b00;
      axi.b_id_i = v.bad_b_id ? IdW'(TID + 1) : IdW'(TID);
      #1 chk("b_ready_held", axi.b_ready_o, 1'b1);
      @(posedge clk); #1;
      axi.b_valid_i = 1'b0; axi.b_resp_i = 2'b00; axi.b_id_i = IdW'(TID);
      #1 check_done("wr", v.exp_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no summary by %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    //          wr    addr                len     eb  last stall n  bresp bid  rej   err   base
    vecs[0]  = '{1'b0, 64'h0000_0000_8000_0000, 8'd0,   -1, -1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_0001};
    vecs[1]  = '{1'b0, 64'h0000_0000_8000_0100, 8'd7,    3, -1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1111_0000_0000_0000};
    vecs[2]  = '{1'b0, 64'h0000_0000_8000_0200, 8'd3,   -1, -1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h2222_0000_0000_0010};
    vecs[3]  = '{1'b0, 64'h0000_0000_8000_0FF8, 8'd1,   -1, -1, -1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0};
    vecs[4]  = '{1'b1, 64'h0000_0000_8000_0FF8, 8'd0,   -1, -1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h4444_0000_0000_0000};
    vecs[5]  = '{1'b1, 64'h0000_0000_8000_1000, 8'd3,   -1, -1,  2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 64'h5555_0000_0000_0100};
    vecs[6]  = '{1'b0, 64'h0000_0000_8000_0000, 8'd3,   -1,  1,  1, 5, 1'b0, 1'b0, 1'b0, 1'b1, 64'h6666_0000_0000_0000};
    vecs[7]  = '{1'b1, 64'h0000_0000_8000_2000, 8'd2,   -1, -1, -1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h7777_0000_0000_0000};
    vecs[8]  = '{1'b1, 64'h0000_0000_8000_3000, 8'd1,   -1, -1, -1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h8888_0000_0000_0000};
    vecs[9]  = '{1'b1, 64'h0000_0000_8000_0F08, 8'd31,  -1, -1, -1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0};
    vecs[10] = '{1'b0, 64'h0000_0000_8000_0040, 8'd1,   -1,  2, -1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hAAAA_0000_0000_0000};
    vecs[11] = '{1'b0, 64'h0000_0000_8000_0000, 8'd255, -1, -1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 64'hBBBB_0000_0000_0000};
    fresh    = '{1'b0, 64'h0000_0000_8000_0800, 8'd2,   -1, -1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 64'hCCCC_0000_0000_0000};

    clear_slave();
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_ar_valid", axi.ar_valid_o, 1'b0);
    chk("rst_aw_valid", axi.aw_valid_o, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_state", state, 3'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    chk("post_rst_done", done, 1'b0);

    for (int i = 0; i < 12; i++) do_txn(vecs[i]);

    // Reset while the second write beat is being presented.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 64'h8000_4000; cmd_len = 8'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0; axi.aw_ready_i = 1'b1;
    @(posedge clk); #1;
    axi.aw_ready_i = 1'b0; axi.w_ready_i = 1'b1; wdata_valid = 1'b1; wdata = 64'h1;
    @(posedge clk); #1;
    wdata = 64'h2;
    #1 chk("mid_w_valid", axi.w_valid_o, 1'b1);
    chk("mid_w_last", axi.w_last_o, 1'b0);
    rst_n = 1'b0;
    #1 chk("arst_w_valid", axi.w_valid_o, 1'b0);
    chk("arst_wdata_ready", wdata_ready, 1'b0);
    chk("arst_b_ready", axi.b_ready_o, 1'b0);
    chk("arst_aw_ar_valid", axi.aw_valid_o | axi.ar_valid_o, 1'b0);
    chk("arst_cmd_ready", cmd_ready, 1'b0);
    chk("arst_state", state, 3'd0);
    @(posedge clk); #1;
    chk("arst_hold_w_valid", axi.w_valid_o, 1'b0);
    clear_slave();
    rst_n = 1'b1;
    #1 chk("rel_cmd_ready", cmd_ready, 1'b1);
    chk("rel_done", done, 1'b0);
    chk("rel_err", err, 1'b0);
    do_txn(fresh);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
